// File: rtl/prog_loader.sv
// Program-image loader: takes length-prefixed, checksummed word stream from the
// UART word assembler and writes it into instruction memory from address 0.
module prog_loader #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           rword,
   input  logic                  rword_ready,
   input  logic                  rearm,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  loading,
   output logic                  done,
   output logic                  len_err,
   output logic                  cksum_err
);

   localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

   typedef enum logic [1:0] {
      WAIT_LEN,
      WAIT_DATA,
      WAIT_SUM,
      DONE
   } state_t;

   state_t state, state_nxt;

   // Counter and length are one bit wider than the address so a full-memory image terminates.
   logic [ADDR_WIDTH:0]   len_q, len_nxt;
   logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
   logic [31:0]           sum, sum_nxt;
   logic                  mem_we_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt;
   logic [31:0]           mem_wdata_nxt;
   logic                  loading_nxt;
   logic                  done_nxt;
   logic                  len_err_nxt;
   logic                  cksum_err_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= WAIT_LEN;
         len_q     <= '0;
         cnt       <= '0;
         sum       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         loading   <= 1'b0;
         done      <= 1'b0;
         len_err   <= 1'b0;
         cksum_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         len_q     <= len_nxt;
         cnt       <= cnt_nxt;
         sum       <= sum_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         loading   <= loading_nxt;
         done      <= done_nxt;
         len_err   <= len_err_nxt;
         cksum_err <= cksum_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      len_nxt       = len_q;
      cnt_nxt       = cnt;
      sum_nxt       = sum;
      mem_we_nxt    = 1'b0;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      done_nxt      = done;
      len_err_nxt   = len_err;
      cksum_err_nxt = cksum_err;

      // rearm wins over a coincident word, which is simply dropped.
      if (rearm) begin
         state_nxt     = WAIT_LEN;
         done_nxt      = 1'b0;
         len_err_nxt   = 1'b0;
         cksum_err_nxt = 1'b0;
      end else if (rword_ready) begin
         case (state)
            WAIT_LEN: begin
               if ({1'b0, rword} > CAPACITY) begin
                  len_err_nxt = 1'b1;
                  done_nxt    = 1'b1;
                  state_nxt   = DONE;
               end else if (rword == 32'd0) begin
                  sum_nxt   = '0;
                  state_nxt = WAIT_SUM;
               end else begin
                  len_nxt   = rword[ADDR_WIDTH:0];
                  cnt_nxt   = '0;
                  sum_nxt   = '0;
                  state_nxt = WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               mem_we_nxt    = 1'b1;
               mem_addr_nxt  = cnt[ADDR_WIDTH-1:0];
               mem_wdata_nxt = rword;
               sum_nxt       = sum + rword;
               cnt_nxt       = cnt + (ADDR_WIDTH+1)'(1);
               if (cnt_nxt == len_q) state_nxt = WAIT_SUM;
            end
            WAIT_SUM: begin
               cksum_err_nxt = (rword != sum);
               done_nxt      = 1'b1;
               state_nxt     = DONE;
            end
            default: begin
            end
         endcase
      end

      loading_nxt = (state_nxt == WAIT_DATA) || (state_nxt == WAIT_SUM);
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Consumes the 32-bit word stream produced by the UART word assembler and writes a length-prefixed, checksummed program image into instruction memory starting at word address 0. It sits between the UART receive path and the instruction-memory write port, and reports completion and error status to the core-release logic.

## Interface

Parameters:
- ADDR_WIDTH, 14: instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- rword  input  32  received word; valid only in the cycle rword_ready is high.
- rword_ready  input  1  single-cycle pulse, one per received word.
- rearm  input  1  single-cycle pulse; aborts or finishes and returns to WAIT_LEN.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse.
- mem_addr  output  ADDR_WIDTH  write word address.
- mem_wdata  output  32  write data.
- loading  output  1  high while in WAIT_DATA or WAIT_SUM.
- done  output  1  level; high in DONE.
- len_err  output  1  level; header length exceeded capacity.
- cksum_err  output  1  level; checksum mismatch.

## Operation

- Image format: word 0 = length N (unsigned 32-bit); then N data words; then one checksum word = sum of the N data words mod 2**32.
- States: WAIT_LEN, WAIT_DATA, WAIT_SUM, DONE. Reset state WAIT_LEN.
- WAIT_LEN, rword_ready:
  - N > 2**ADDR_WIDTH: set len_err, go to DONE (no memory writes, no checksum consumed).
  - N == 0: clear sum, go to WAIT_SUM.
  - otherwise: latch N, clear write counter and sum, go to WAIT_DATA.
- WAIT_DATA, rword_ready: write rword at address = counter; sum += rword (32-bit wrap); counter += 1; when counter reaches N, go to WAIT_SUM. Counter is ADDR_WIDTH+1 bits so N = 2**ADDR_WIDTH terminates correctly; mem_addr is its low ADDR_WIDTH bits.
- WAIT_SUM, rword_ready: cksum_err <= (rword != sum); go to DONE.
- DONE: rword_ready ignored; outputs held.
- rearm in any state: next state WAIT_LEN; done, len_err, cksum_err, loading cleared; mem_we low. rearm has priority over a simultaneous rword_ready (that word is dropped).
- rword_ready with no state transition pending (e.g. in DONE) has no effect.

## Timing

- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, loading 0, done 0, len_err 0, cksum_err 0; counter, sum, N cleared.
- All outputs registered.
- Data word: mem_we/mem_addr/mem_wdata valid in the cycle after its rword_ready; mem_we high exactly one cycle per data word; mem_addr/mem_wdata hold between writes.
- loading rises the cycle after the header word's rword_ready (N != 0 or N == 0 within capacity), falls with done's rise.
- done and cksum_err update the cycle after the checksum word's rword_ready; len_err and done rise the cycle after an oversize header's rword_ready.
- Back-to-back rword_ready every cycle is supported with no loss.
- Reset asserted mid-load: immediate return to reset values; memory contents already written are not erased.

## Test plan

- ADDR_WIDTH=4; words 3, 0x11, 0x22, 0x33, 0x66 -> three mem_we pulses at addr 0,1,2 with data 0x11,0x22,0x33; done=1, cksum_err=0, len_err=0.
- Same image with checksum 0x67 -> writes identical, done=1, cksum_err=1.
- Header 0, then 0 -> no mem_we, done=1, cksum_err=0; header 0 then 5 -> cksum_err=1.
- ADDR_WIDTH=4; header 17 -> len_err=1, done=1, no mem_we; following words ignored; header 16 with 16 words 0xFFFFFFFF and checksum 0xFFFFFFF0 -> last write at addr 15, cksum_err=0.
- Header 4, two data words, rearm coincident with third word -> third word dropped, all status 0, next image 1, 0xAB, 0xAB writes addr 0 and completes clean.
- Reset pulled low during WAIT_DATA with rword_ready every cycle -> all outputs 0 asynchronously; after release loader accepts a new header.
